// File: rtl/branch_pkg.sv
// branch_pkg: shared funct3 encodings and default widths for the branch unit
package branch_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int CNT_W_DEF = 32;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/branch_stats.sv
// branch_stats: debug statistics for taken branches
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   taken      in   a branch is taken this cycle
//   taken_cnt  out  saturating count of taken branches
//   last_taken out  taken from the previous cycle
module branch_stats
    import branch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             last_taken
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt  <= '0;
            last_taken <= 1'b0;
        end else begin
            last_taken <= taken;
            // hold at all-ones so the counter never wraps
            if (taken && !(&taken_cnt))
                taken_cnt <= taken_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/branch_unit.sv
// branch_unit: combinational branch decision for the RV64 datapath plus taken stats
//   clk        in   clock (stats only)
//   rst_n      in   asynchronous active-low reset (stats only)
//   Result     in   ALU result of rs1 - rs2
//   Funct      in   instruction funct3
//   Branch     in   current instruction is a conditional branch
//   BLT/BGE/BEQ/BNE out  per-condition branch taken
//   Taken      out  any branch taken
//   taken_cnt  out  saturating taken-branch count
//   last_taken out  Taken registered from the previous cycle
// Less-than uses only the sign of rs1 - rs2 with no overflow correction, so
// operand pairs whose subtraction overflows are misjudged; BLTU/BGEU never fire.
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  Result,
    input  logic [2:0]       Funct,
    input  logic             Branch,
    output logic             BLT,
    output logic             BGE,
    output logic             BEQ,
    output logic             BNE,
    output logic             Taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             last_taken
);
    logic neg;
    logic zero;

    assign neg  = Result[XLEN-1];
    assign zero = (Result == '0);

    // plain AND terms so an X on Branch shows up on the outputs
    assign BLT   = Branch & (Funct == F3_BLT) & neg;
    assign BGE   = Branch & (Funct == F3_BGE) & ~neg;
    assign BEQ   = Branch & (Funct == F3_BEQ) & zero;
    assign BNE   = Branch & (Funct == F3_BNE) & ~zero;
    assign Taken = BLT | BGE | BEQ | BNE;

    branch_stats #(.CNT_W(CNT_W)) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .taken      (Taken),
        .taken_cnt  (taken_cnt),
        .last_taken (last_taken)
    );
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: randomized self-checking bench for branch_unit
module tb_branch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] Result;
    logic [2:0]  Funct;
    logic        Branch;
    logic        BLT, BGE, BEQ, BNE, Taken, last_taken;
    logic [31:0] taken_cnt;
    logic        BLT4, BGE4, BEQ4, BNE4, Taken4, last_taken4;
    logic [3:0]  taken_cnt4;

    int total = 0;
    int bad   = 0;
    longint m_cnt32 = 0;
    longint m_cnt4  = 0;
    logic   m_last  = 1'b0;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk(clk), .rst_n(rst_n), .Result(Result), .Funct(Funct), .Branch(Branch),
        .BLT(BLT), .BGE(BGE), .BEQ(BEQ), .BNE(BNE), .Taken(Taken),
        .taken_cnt(taken_cnt), .last_taken(last_taken)
    );

    branch_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Result(Result), .Funct(Funct), .Branch(Branch),
        .BLT(BLT4), .BGE(BGE4), .BEQ(BEQ4), .BNE(BNE4), .Taken(Taken4),
        .taken_cnt(taken_cnt4), .last_taken(last_taken4)
    );

    // expected {BLT,BGE,BEQ,BNE} straight from the branch rules
    function automatic logic [3:0] exp_dec(logic b, logic [2:0] f, logic [63:0] r);
        bit is_neg  = (r >= 64'h8000_0000_0000_0000);
        bit is_zero = (r == 64'd0);
        if (!b) return 4'b0000;
        case (f)
            3'b100:  return is_neg  ? 4'b1000 : 4'b0000;
            3'b101:  return is_neg  ? 4'b0000 : 4'b0100;
            3'b000:  return is_zero ? 4'b0010 : 4'b0000;
            3'b001:  return is_zero ? 4'b0000 : 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic apply(input logic b, input logic [2:0] f, input logic [63:0] r);
        Branch = b;
        Funct  = f;
        Result = r;
    endtask

    // advance one rising edge, keep the model in step, then settle
    task automatic tick();
        logic t;
        @(posedge clk);
        t = |exp_dec(Branch, Funct, Result);
        if (rst_n) begin
            m_last = t;
            if (t) begin
                m_cnt32 = m_cnt32 + 1;
                if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(1'b1, 3'b000, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (taken_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt actual=%0d required=0", taken_cnt); end
        total++;
        if (last_taken !== 1'b0) begin bad++; $display("FAIL reset_last actual=%b required=0", last_taken); end
        total++;
        if (taken_cnt4 !== 4'd0) begin bad++; $display("FAIL reset_cnt4 actual=%0d required=0", taken_cnt4); end
        total++;
        if ({BLT, BGE, BEQ, BNE, Taken} !== 5'b00101) begin
            bad++; $display("FAIL decode_in_reset actual=%b required=00101", {BLT, BGE, BEQ, BNE, Taken});
        end
    endtask

    task automatic test_decode_directed();
        logic [2:0]  fs [14] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b100, 3'b101, 3'b100,
                                 3'b000, 3'b001, 3'b000, 3'b001, 3'b110, 3'b111, 3'b010};
        logic        bs [14] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        logic [63:0] rs [14] = '{64'h8000_0000_0000_0004, 64'd4, 64'd4,
                                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                 64'd4, 64'h8000_0000_0000_0001, 64'd0, 64'd0, 64'd5, 64'd5,
                                 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        logic [4:0]  ex [14] = '{5'b10001, 5'b00000, 5'b01001, 5'b00000, 5'b10001,
                                 5'b00000, 5'b00000, 5'b00101, 5'b00000, 5'b00000,
                                 5'b00011, 5'b00000, 5'b00000, 5'b00000};
        for (int i = 0; i < 14; i++) begin
            apply(bs[i], fs[i], rs[i]);
            #1;
            total++;
            if ({BLT, BGE, BEQ, BNE, Taken} !== ex[i]) begin
                bad++;
                $display("FAIL directed_%0d actual=%b required=%b", i, {BLT, BGE, BEQ, BNE, Taken}, ex[i]);
            end
        end
    endtask

    task automatic test_count();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 3'b000, 64'd0);
        repeat (3) tick();
        total++;
        if (taken_cnt !== 32'd3) begin bad++; $display("FAIL count3 actual=%0d required=3", taken_cnt); end
        total++;
        if (last_taken !== 1'b1) begin bad++; $display("FAIL count_last actual=%b required=1", last_taken); end
        #2;
        rst_n = 1'b0;
        m_cnt32 = 0; m_cnt4 = 0; m_last = 1'b0;
        #1;
        total++;
        if (taken_cnt !== 32'd0 || last_taken !== 1'b0) begin
            bad++; $display("FAIL async_reset actual=%0d/%b required=0/0", taken_cnt, last_taken);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 3'b101, 64'd7);
        repeat (20) tick();
        total++;
        if (taken_cnt4 !== 4'd15) begin bad++; $display("FAIL saturate4 actual=%0d required=15", taken_cnt4); end
        total++;
        if (taken_cnt !== 32'd20) begin bad++; $display("FAIL count20 actual=%0d required=20", taken_cnt); end
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [3:0]  e;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       r = 64'd0;
                1:       r = 64'($urandom_range(1, 1000));
                2:       r = {1'b1, 31'($urandom()), 32'($urandom())};
                default: r = {32'($urandom()), 32'($urandom())};
            endcase
            apply(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), r);
            #1;
            e = exp_dec(Branch, Funct, Result);
            total++;
            if ({BLT, BGE, BEQ, BNE, Taken} !== {e, |e}) begin
                bad++;
                $display("FAIL rand_decode b=%b f=%b r=%h actual=%b required=%b",
                         Branch, Funct, Result, {BLT, BGE, BEQ, BNE, Taken}, {e, |e});
            end
            tick();
            total++;
            if (taken_cnt !== 32'(m_cnt32) || taken_cnt4 !== 4'(m_cnt4) || last_taken !== m_last) begin
                bad++;
                $display("FAIL rand_stats actual=%0d/%0d/%b required=%0d/%0d/%b",
                         taken_cnt, taken_cnt4, last_taken, m_cnt32, m_cnt4, m_last);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(1'b1, 3'b001, (i % 2 == 0) ? 64'd9 : 64'd0);
            tick();
            total++;
            if (last_taken !== m_last || taken_cnt !== 32'(m_cnt32)) begin
                bad++;
                $display("FAIL b2b_%0d actual=%b/%0d required=%b/%0d", i, last_taken, taken_cnt, m_last, m_cnt32);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode_directed();
        test_count();
        test_saturate();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Branch-decision block for the RV64 single-cycle datapath.
- Consumes the ALU subtraction result (rs1 - rs2), funct3 and the control unit's Branch strobe.
- Asserts the per-condition branch signals that feed the PC-select mux.
- Decision path is purely combinational (zero latency). A small clocked stats section counts taken branches for debug.

Parameters:
- XLEN, 64, width of Result; sign bit is Result[XLEN-1].
- CNT_W, 32, width of taken-branch counter.

Ports:
- clk  input  1  system clock; used only by stats registers.
- rst_n  input  1  asynchronous active-low reset.
- Result  input  XLEN  ALU result of rs1 - rs2.
- Funct  input  3  instruction funct3.
- Branch  input  1  control-unit strobe; current instruction is a conditional branch.
- BLT  output  1  branch-if-less-than taken.
- BGE  output  1  branch-if-greater-or-equal taken.
- BEQ  output  1  branch-if-equal taken.
- BNE  output  1  branch-if-not-equal taken.
- Taken  output  1  OR of BLT, BGE, BEQ, BNE.
- taken_cnt  output  CNT_W  saturating count of taken branches.
- last_taken  output  1  registered Taken from previous cycle.

Behaviour:
- Sign bit is Result[XLEN-1]; zero flag Z is Result == 0.
- Sign-bit-only compare; no overflow correction. Pass that limitation to the datapath owner.
- All decode outputs are combinational and settle in the same delta as their inputs:
  - BLT = Branch & (Funct == 3'b100) & Result[XLEN-1].
  - BGE = Branch & (Funct == 3'b101) & ~Result[XLEN-1].
  - BEQ = Branch & (Funct == 3'b000) & Z.
  - BNE = Branch & (Funct == 3'b001) & ~Z.
  - Taken = BLT | BGE | BEQ | BNE.
- Branch = 0 forces all five decode outputs to 0, regardless of Funct or Result.
- Funct values 010, 011, 110, 111 give all decode outputs 0. 110 (BLTU) and 111 (BGEU) are unsupported here.
- At most one decode output is high at any time; the conditions are mutually exclusive by Funct.
- Decode outputs are independent of clk and rst_n; they stay valid while in reset.
- Stats registers, on each rising clk edge:
  - last_taken <= Taken.
  - If Taken and taken_cnt != all-ones, taken_cnt <= taken_cnt + 1; otherwise hold.
  - taken_cnt saturates at 2^CNT_W - 1 and does not wrap.
- Reset:
  - rst_n low asynchronously forces taken_cnt = 0 and last_taken = 0 immediately.
  - Registers hold reset while rst_n is low. First update is on the first rising edge after rst_n goes high.
  - Reset asserted mid-count clears the counter at once.
- X on Branch propagates to the decode outputs. The counter does not need to be X-safe.

Decomposition:
- Shared package branch_pkg:
  - funct3 constants F3_BEQ = 000, F3_BNE = 001, F3_BLT = 100, F3_BGE = 101, F3_BLTU = 110, F3_BGEU = 111.
  - XLEN default.
- One natural sub-module, branch_stats: counter plus last_taken register, fed by Taken.
- Decode logic stays inline in branch_unit.

Test Plan:
- Result = 64'h8000_0000_0000_0004, Funct = 100, Branch = 1 -> BLT = 1, BGE = 0, Taken = 1.
- Result = 64'd4, Funct = 100 -> BLT = 0. Then Funct = 101 -> BGE = 1.
- Funct = 101, Result[63] = 1 -> BGE = 0. Then Funct = 100 -> BLT = 1. Then Branch = 0 -> all decode outputs 0, also for Funct = 101.
- Result = 0: Funct = 000 -> BEQ = 1; Funct = 001 -> BNE = 0. Result = 5: BEQ = 0, BNE = 1. Funct = 110 or 111 with any Result -> all 0.
- rst_n low then released; Taken held 1 for 3 clocks -> taken_cnt = 3, last_taken = 1. Assert rst_n low between edges -> taken_cnt = 0 and last_taken = 0 immediately.
- With CNT_W = 4, Taken held 1 for 20 clocks -> taken_cnt stays at 15.
